button_conditioner: RTL

//   Conditions the four raw paddle push-buttons (P1 up/down, P2 up/down) before they reach paddle_control.
//   Per channel: synchronises the asynchronous pad input, debounces it, and emits a clean level plus one-cycle press/release strobes.

---
 rtl/pong_pkg.sv | 26 ++
 rtl/debounce_channel.sv | 180 ++++++++++++++++++
 rtl/button_conditioner.sv | 61 ++++++
 3 files changed

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
//   Shared constants and types for the pong front end.
//   - BTN_* : bit positions of the four paddle buttons on btn_raw/btn_level.
//             Pairs are {BTN_P1D,BTN_P1U} and {BTN_P2D,BTN_P2U}.
//   - DB_CYCLES_DEFAULT : debounce window used by the top level
//             (10 ms at 100 MHz).
//   - btn_state_t : per-channel debounce FSM states.
// -----------------------------------------------------------------------------
package pong_pkg;

   localparam int BTN_P1U = 0;
   localparam int BTN_P1D = 1;
   localparam int BTN_P2U = 2;
   localparam int BTN_P2D = 3;

   localparam int DB_CYCLES_DEFAULT = 1_000_000;

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } btn_state_t;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: synchroniser chain, debounce FSM with a saturating
//   hold counter, and registered press/release strobes. With BTN_REPEAT_EN
//   defined, a held button also produces auto-repeat press strobes.
//   Ports:
//     clk    in  1  system clock
//     reset  in  1  synchronous, active-high reset
//     raw    in  1  asynchronous pad input
//     stable out 1  debounced level
//     press  out 1  1-cycle strobe on accepted 0->1 (and auto-repeats)
//     rel    out 1  1-cycle strobe on accepted 1->0
//   Optional feature macro: BTN_REPEAT_EN
// -----------------------------------------------------------------------------
module debounce_channel
   import pong_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int DB_CYCLES     = DB_CYCLES_DEFAULT,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic press,
   output logic rel
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s;
   btn_state_t             state_reg, state_next;
   logic [CW-1:0]          cnt_reg, cnt_next;
   logic                   stable_reg, stable_next;
   logic                   press_reg, press_next;
   logic                   rel_reg, rel_next;
   logic                   accept_press;
   logic                   repeat_fire;

   assign s = sync_reg[SYNC_STAGES-1];

   // Debounce FSM. A WAIT state is only left towards the new level once the
   // counter has reached its last value, so the counter never passes
   // CNT_LAST (it saturates by construction). Any bounce returns to the
   // IDLE state and the next attempt starts the window from zero.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      stable_next  = stable_reg;
      accept_press = 1'b0;
      rel_next     = 1'b0;
      case (state_reg)
         IDLE_LO: begin
            if (s) begin
               state_next = WAIT_HI;
               cnt_next   = '0;
            end
         end
         WAIT_HI: begin
            if (!s) begin
               state_next = IDLE_LO;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next   = IDLE_HI;
               stable_next  = 1'b1;
               accept_press = 1'b1;
               cnt_next     = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         IDLE_HI: begin
            if (!s) begin
               state_next = WAIT_LO;
               cnt_next   = '0;
            end
         end
         WAIT_LO: begin
            if (s) begin
               state_next = IDLE_HI;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next  = IDLE_LO;
               stable_next = 1'b0;
               rel_next    = 1'b1;
               cnt_next    = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = IDLE_LO;
            cnt_next   = '0;
         end
      endcase
   end

`ifdef BTN_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam logic [RW-1:0] RDELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rcnt_reg, rcnt_next;
   logic          rphase_reg, rphase_next;   // 0: first delay, 1: periodic

   // Repeat counter runs only while the button sits accepted-high. A trip
   // into WAIT_LO freezes it; a bounce back restarts it towards the
   // periodic interval rather than the initial delay.
   always_comb begin
      rcnt_next   = rcnt_reg;
      rphase_next = rphase_reg;
      repeat_fire = 1'b0;
      case (state_reg)
         IDLE_HI: begin
            if (s) begin
               if (rcnt_reg == (rphase_reg ? RPERIOD_LAST : RDELAY_LAST)) begin
                  repeat_fire = 1'b1;
                  rcnt_next   = '0;
                  rphase_next = 1'b1;
               end else begin
                  rcnt_next = rcnt_reg + RW'(1);
               end
            end
         end
         WAIT_LO: begin
            if (s) begin
               rcnt_next   = '0;
               rphase_next = 1'b1;
            end
         end
         default: begin
            rcnt_next   = '0;
            rphase_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rcnt_reg   <= '0;
         rphase_reg <= 1'b0;
      end else begin
         rcnt_reg   <= rcnt_next;
         rphase_reg <= rphase_next;
      end
   end
`else
   assign repeat_fire = 1'b0;
`endif

   assign press_next = accept_press | repeat_fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg   <= '0;
         state_reg  <= IDLE_LO;
         cnt_reg    <= '0;
         stable_reg <= 1'b0;
         press_reg  <= 1'b0;
         rel_reg    <= 1'b0;
      end else begin
         sync_reg   <= {sync_reg[SYNC_STAGES-2:0], raw};
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         stable_reg <= stable_next;
         press_reg  <= press_next;
         rel_reg    <= rel_next;
      end
   end

   assign stable = stable_reg;
   assign press  = press_reg;
   assign rel    = rel_reg;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions the four raw paddle buttons for paddle_control: one
//   debounce_channel per button, then a per-player up/down conflict mask on
//   the levels (both held -> neither asserted). Strobes are not masked.
//   Ports:
//     clk          in  1      system clock (shared with paddle_control)
//     reset        in  1      synchronous, active-high reset
//     btn_raw      in  N_BTN  raw pads [0]=P1U [1]=P1D [2]=P2U [3]=P2D
//     btn_level    out N_BTN  debounced, conflict-masked levels
//     btn_press    out N_BTN  1-cycle press strobes (plus auto-repeats)
//     btn_release  out N_BTN  1-cycle release strobes
//   Optional feature macro: BTN_REPEAT_EN (auto-repeat press strobes)
// -----------------------------------------------------------------------------
module button_conditioner
   import pong_pkg::*;
#(
   parameter int N_BTN         = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int DB_CYCLES     = DB_CYCLES_DEFAULT,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   logic [N_BTN-1:0] stable;

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_ch
         debounce_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
         ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .raw    (btn_raw[gi]),
            .stable (stable[gi]),
            .press  (btn_press[gi]),
            .rel    (btn_release[gi])
         );
      end

      // Buttons come in (up, down) pairs, one pair per player.
      for (gi = 0; gi < N_BTN / 2; gi++) begin : g_pair
         localparam int U = 2 * gi + BTN_P1U;
         localparam int D = 2 * gi + BTN_P1D;
         assign btn_level[U] = stable[U] & ~stable[D];
         assign btn_level[D] = stable[D] & ~stable[U];
      end
   endgenerate

endmodule
